// File: rtl/pid_wr_master.sv
// Write-bus initiator for the PID channel filters: assembles 6-word host frames
// into single-channel or broadcast register writes and rejects malformed frames.
module pid_wr_master #(
  parameter int N_CHAN    = 20,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 5,
  parameter int W_WR_DATA = 49,
  parameter int TIMEOUT   = 1024,
  parameter int W_ERR     = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 pipe_valid,
  input  logic [15:0]          pipe_data,
  output logic                 pipe_ready,
  output logic                 wr_en,
  output logic [W_WR_ADDR-1:0] wr_addr,
  output logic [W_WR_CHAN-1:0] wr_chan,
  output logic [W_WR_DATA-1:0] wr_data,
  output logic                 busy,
  output logic [W_ERR-1:0]     err_count
);

  typedef enum logic [1:0] {IDLE, CHAN, DATA, ISSUE} state_e;

  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [W_WR_CHAN-1:0] LAST_CHAN = W_WR_CHAN'(N_CHAN - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

  state_e               state_q;
  logic [W_WR_ADDR-1:0] addr_q;
  logic [W_WR_CHAN-1:0] chan_q;
  logic                 bcast_q;
  logic [1:0]           cnt_q;
  logic [47:0]          data_q;
  logic [GW-1:0]        gap_q;
  logic                 wr_en_q;
  logic [W_WR_ADDR-1:0] wr_addr_q;
  logic [W_WR_CHAN-1:0] wr_chan_q;
  logic [W_WR_DATA-1:0] wr_data_q;
  logic [W_ERR-1:0]     err_q;

  logic                 accept;
  logic                 chan_ok;
  logic                 timeout_hit;
  logic [63:0]          full_data;
  logic [W_ERR-1:0]     err_d;
  logic                 unused_data_bits;

  assign pipe_ready  = !rst_in && (state_q != ISSUE);
  assign accept      = pipe_valid && pipe_ready;
  assign busy        = (state_q != IDLE);
  assign full_data   = {pipe_data, data_q};
  assign chan_ok     = bcast_q || ({{(32-W_WR_CHAN){1'b0}}, chan_q} < 32'(N_CHAN));
  assign timeout_hit = (gap_q == GAP_LAST);
  assign err_d       = (err_q == '1) ? err_q : err_q + 1'b1;
  assign unused_data_bits = ^full_data;

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_chan   = wr_chan_q;
  assign wr_data   = wr_data_q;
  assign err_count = err_q;

  // Frame assembly, inter-word timeout and write issue share one state register;
  // data words shift in from the top so w2 ends up least significant.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      chan_q    <= '0;
      bcast_q   <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      gap_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_chan_q <= '0;
      wr_data_q <= '0;
      err_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_q <= '0;
          if (accept) begin
            addr_q  <= pipe_data[W_WR_ADDR-1:0];
            state_q <= CHAN;
          end
        end
        CHAN: begin
          if (accept) begin
            chan_q  <= pipe_data[W_WR_CHAN-1:0];
            bcast_q <= pipe_data[15];
            cnt_q   <= '0;
            gap_q   <= '0;
            state_q <= DATA;
          end else if (timeout_hit) begin
            gap_q   <= '0;
            err_q   <= err_d;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            gap_q  <= '0;
            cnt_q  <= cnt_q + 2'd1;
            data_q <= {pipe_data, data_q[47:16]};
            if (cnt_q == 2'd3) begin
              if (chan_ok) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_chan_q <= bcast_q ? '0 : chan_q;
                wr_data_q <= full_data[W_WR_DATA-1:0];
                state_q   <= ISSUE;
              end else begin
                err_q   <= err_d;
                state_q <= IDLE;
              end
            end
          end else if (timeout_hit) begin
            gap_q   <= '0;
            err_q   <= err_d;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        ISSUE: begin
          gap_q <= '0;
          // A broadcast walks wr_chan itself as the channel index.
          if (bcast_q && (wr_chan_q != LAST_CHAN)) begin
            wr_chan_q <= wr_chan_q + 1'b1;
          end else begin
            wr_en_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_wr_master.sv
// Scoreboard bench for pid_wr_master: a frame-level model queues expected writes,
// and a monitor pops and compares them whenever wr_en is seen.
module tb_pid_wr_master;

  localparam int N_CHAN    = 20;
  localparam int W_WR_ADDR = 16;
  localparam int W_WR_CHAN = 5;
  localparam int W_WR_DATA = 49;
  localparam int TIMEOUT   = 16;
  localparam int W_ERR     = 8;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 pipe_valid = 1'b0;
  logic [15:0]          pipe_data = '0;
  logic                 pipe_ready;
  logic                 wr_en;
  logic [W_WR_ADDR-1:0] wr_addr;
  logic [W_WR_CHAN-1:0] wr_chan;
  logic [W_WR_DATA-1:0] wr_data;
  logic                 busy;
  logic [W_ERR-1:0]     err_count;

  pid_wr_master #(
    .N_CHAN(N_CHAN), .W_WR_ADDR(W_WR_ADDR), .W_WR_CHAN(W_WR_CHAN),
    .W_WR_DATA(W_WR_DATA), .TIMEOUT(TIMEOUT), .W_ERR(W_ERR)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .pipe_valid(pipe_valid), .pipe_data(pipe_data),
    .pipe_ready(pipe_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan),
    .wr_data(wr_data), .busy(busy), .err_count(err_count)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  typedef struct {
    logic [W_WR_ADDR-1:0] addr;
    logic [W_WR_CHAN-1:0] chan;
    logic [W_WR_DATA-1:0] data;
    int                   cyc;
  } wr_t;

  wr_t expQ[$];
  wr_t monE;
  int  total = 0;
  int  bad = 0;
  int  expErr = 0;
  int  strobes = 0;
  int  lastStrobe = 0;
  int  prevStrobe = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge clk_in) begin
    if (wr_en === 1'b1) begin
      strobes++;
      prevStrobe = lastStrobe;
      lastStrobe = cyc;
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_strobe: got wr_en=1 chan=%0d expected no write (cycle %0d)", wr_chan, cyc);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(monE.addr));
        checkOutput("wr_chan", 64'(wr_chan), 64'(monE.chan));
        checkOutput("wr_data", 64'(wr_data), 64'(monE.data));
        checkOutput("wr_cycle", 64'(cyc), 64'(monE.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the word is taken.
  task automatic sendWord(input logic [15:0] w, output int acceptCyc);
    bit done;
    done = 0;
    acceptCyc = 0;
    pipe_valid = 1'b1;
    pipe_data  = w;
    for (int i = 0; i < 200 && !done; i++) begin
      if (pipe_ready === 1'b1) begin
        acceptCyc = cyc;
        @(posedge clk_in);
        @(negedge clk_in);
        done = 1;
      end else begin
        @(negedge clk_in);
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: got no pipe_ready expected acceptance of 0x%0h", w);
    end
  endtask

  task automatic idle(input int n);
    pipe_valid = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic applyStimulus(input logic [15:0] w [6], input int gapMax);
    int t;
    logic [63:0] full;
    logic [W_WR_DATA-1:0] d;
    wr_t e;
    t = 0;
    for (int i = 0; i < 6; i++) begin
      if (gapMax > 0) idle($urandom_range(0, gapMax));
      sendWord(w[i], t);
    end
    pipe_valid = 1'b0;
    full = {w[5], w[4], w[3], w[2]};
    d = full[W_WR_DATA-1:0];
    if (w[1][15]) begin
      for (int k = 0; k < N_CHAN; k++) begin
        e.addr = w[0][W_WR_ADDR-1:0]; e.chan = W_WR_CHAN'(k); e.data = d; e.cyc = t + 1 + k;
        expQ.push_back(e);
      end
    end else if (int'(w[1][W_WR_CHAN-1:0]) < N_CHAN) begin
      e.addr = w[0][W_WR_ADDR-1:0]; e.chan = w[1][W_WR_CHAN-1:0]; e.data = d; e.cyc = t + 1;
      expQ.push_back(e);
    end else begin
      if (expErr < (1 << W_ERR) - 1) expErr++;
    end
  endtask

  logic [15:0] fr [6];
  int tmp;
  int n;
  int sSeen;
  int kind;

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    checkOutput("ready_in_reset", 64'(pipe_ready), 64'd0);
    checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
    checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
    checkOutput("reset_wr_chan", 64'(wr_chan), 64'd0);
    checkOutput("reset_wr_data", 64'(wr_data), 64'd0);
    checkOutput("reset_err", 64'(err_count), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("ready_after_reset", 64'(pipe_ready), 64'd1);

    // Single write from the test plan
    fr = '{16'h0004, 16'h0003, 16'h1234, 16'h5678, 16'h9ABC, 16'h0001};
    applyStimulus(fr, 0);
    checkOutput("single_ready_t1", 64'(pipe_ready), 64'd0);
    @(negedge clk_in);
    checkOutput("single_ready_t2", 64'(pipe_ready), 64'd1);
    checkOutput("single_busy_t2", 64'(busy), 64'd0);
    idle(3);

    // Broadcast: ready must stay low for exactly N_CHAN cycles
    fr = '{16'h00A5, 16'h8000, 16'h0007, 16'h0000, 16'h0000, 16'h0000};
    applyStimulus(fr, 0);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (pipe_ready === 1'b1) break;
      n++;
      @(negedge clk_in);
    end
    checkOutput("bcast_ready_low", 64'(n), 64'(N_CHAN));
    idle(2);

    // Invalid channel 21
    fr = '{16'h0010, 16'h0015, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    applyStimulus(fr, 0);
    checkOutput("invalid_busy", 64'(busy), 64'd0);
    checkOutput("invalid_err", 64'(err_count), 64'(expErr));
    fr = '{16'h0011, 16'h0013, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    applyStimulus(fr, 0);
    idle(3);

    // Timeout after w0/w1
    sendWord(16'h0022, tmp);
    sendWord(16'h0002, tmp);
    idle(TIMEOUT - 1);
    checkOutput("timeout_busy_before", 64'(busy), 64'd1);
    checkOutput("timeout_err_before", 64'(err_count), 64'(expErr));
    @(negedge clk_in);
    expErr++;
    checkOutput("timeout_busy_after", 64'(busy), 64'd0);
    checkOutput("timeout_err_after", 64'(err_count), 64'(expErr));
    fr = '{16'h0033, 16'h0009, 16'h0102, 16'h0304, 16'h0506, 16'h0708};
    applyStimulus(fr, 0);
    idle(3);

    // Back-to-back single writes with pipe_valid held high
    fr = '{16'h0040, 16'h0001, 16'h1001, 16'h1002, 16'h1003, 16'h1004};
    applyStimulus(fr, 0);
    fr = '{16'h0041, 16'h0002, 16'h2001, 16'h2002, 16'h2003, 16'h2004};
    applyStimulus(fr, 0);
    idle(3);
    checkOutput("b2b_spacing", 64'(lastStrobe - prevStrobe), 64'd7);

    // Randomized frames: valid, invalid and broadcast with short gaps
    for (int f = 0; f < 15; f++) begin
      kind = $urandom_range(0, 3);
      fr[0] = 16'($urandom);
      if (kind == 0)      fr[1] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      else if (kind == 1) fr[1] = {1'b0, 10'($urandom), 5'($urandom_range(N_CHAN, 31))};
      else                fr[1] = {1'b0, 10'($urandom), 5'($urandom_range(0, N_CHAN - 1))};
      for (int i = 2; i < 6; i++) fr[i] = 16'($urandom);
      applyStimulus(fr, 3);
    end
    idle(2 * N_CHAN);
    checkOutput("random_err", 64'(err_count), 64'(expErr));
    checkOutput("random_drained", 64'(expQ.size()), 64'd0);

    // Reset during the 5th broadcast strobe
    fr = '{16'h0055, 16'h8003, 16'h00EE, 16'h0000, 16'h0000, 16'h0000};
    sSeen = strobes;
    applyStimulus(fr, 0);
    repeat (4) @(negedge clk_in);
    checkOutput("midbc_chan", 64'(wr_chan), 64'd4);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    expQ.delete();
    expErr = 0;
    @(negedge clk_in);
    checkOutput("midbc_strobes", 64'(strobes - sSeen), 64'd5);
    checkOutput("midbc_wr_en", 64'(wr_en), 64'd0);
    checkOutput("midbc_addr", 64'(wr_addr), 64'd0);
    checkOutput("midbc_chan0", 64'(wr_chan), 64'd0);
    checkOutput("midbc_data", 64'(wr_data), 64'd0);
    checkOutput("midbc_err", 64'(err_count), 64'd0);
    checkOutput("midbc_busy", 64'(busy), 64'd0);
    checkOutput("midbc_ready", 64'(pipe_ready), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("midbc_ready_after", 64'(pipe_ready), 64'd1);
    sSeen = strobes;
    idle(N_CHAN + 5);
    checkOutput("midbc_no_resume", 64'(strobes - sSeen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pid_wr_master.md
# pid_wr_master

Write-bus initiator for the PID channel filters. It assembles 16-bit host pipe words into framed register-write commands and drives the `wr_en`/`wr_addr`/`wr_chan`/`wr_data` bus read by the PID filter and its sibling filters. It sits between the host endpoint FIFO and every block on the configuration write bus. It supports single-channel writes and all-channel broadcast writes, and rejects malformed frames.

## Interface
Parameters:
- `N_CHAN`, 20: number of channels on the write bus.
- `W_WR_ADDR`, 16: write address width; must be ≤ 16.
- `W_WR_CHAN`, 5: write channel width; must be ≤ 15.
- `W_WR_DATA`, 49: write data width; must be ≤ 64.
- `TIMEOUT`, 1024: maximum number of idle cycles allowed between words of one frame; must be ≥ 2.
- `W_ERR`, 8: width of the error counter.

Ports:
- `clk_in`  in  1: the single clock.
- `rst_in`  in  1: synchronous, active-high reset.
- `pipe_valid`  in  1: the host word on `pipe_data` is valid.
- `pipe_data`  in  16: host word.
- `pipe_ready`  out  1: the block accepts a word this cycle.
- `wr_en`  out  1: write strobe, one cycle per channel written.
- `wr_addr`  out  W_WR_ADDR: register address.
- `wr_chan`  out  W_WR_CHAN: target channel.
- `wr_data`  out  W_WR_DATA: write data.
- `busy`  out  1: high whenever the state is not IDLE.
- `err_count`  out  W_ERR: saturating count of rejected frames.

## Operation
- A word is accepted on any cycle where `pipe_valid && pipe_ready`.
- Each frame is 6 words, in this order:
  - w0: address. `wr_addr` takes `w0[W_WR_ADDR-1:0]`.
  - w1: channel word. Channel is `w1[W_WR_CHAN-1:0]`. `w1[15]` is the broadcast flag. All other bits are ignored.
  - w2..w5: data, least-significant word first. `wr_data = {w5,w4,w3,w2}[W_WR_DATA-1:0]`. Bits above `W_WR_DATA` are discarded.
- State machine:
  - IDLE: `pipe_ready` = 1. Accepting w0 moves to CHAN.
  - CHAN: `pipe_ready` = 1. Accepting w1 moves to DATA and sets the word counter to 0.
  - DATA: `pipe_ready` = 1. Each accepted word increments the counter. On acceptance of w5 (counter = 3):
    - If broadcast is set, or channel < `N_CHAN`: go to ISSUE.
    - Otherwise: go to IDLE and increment `err_count`.
  - ISSUE: `pipe_ready` = 0 and `wr_en` = 1.
    - Single write: exactly one cycle, with `wr_chan` = the channel field.
    - Broadcast: `N_CHAN` consecutive cycles, `wr_chan` = 0, 1, …, `N_CHAN`-1. The channel field is ignored.
    - After the last write, go to IDLE.
- Timeout:
  - In CHAN and DATA, a gap counter increments on every cycle with no accepted word and clears when a word is accepted.
  - When the counter reaches `TIMEOUT`: go to IDLE, drop the partial frame, increment `err_count`.
  - The gap counter is held at 0 in IDLE and ISSUE.
- `err_count` saturates at all-ones.
- `wr_addr`, `wr_chan` and `wr_data` are registered. They hold their last values outside ISSUE; consumers qualify them with `wr_en` only.
- Reset, including mid-frame or mid-ISSUE:
  - Next state is IDLE and any partial frame is dropped.
  - `wr_en`=0, `wr_addr`=0, `wr_chan`=0, `wr_data`=0, `err_count`=0, `busy`=0.
  - `pipe_ready` is forced to 0 while `rst_in` is high, and is 1 on the first cycle after reset.
  - A broadcast interrupted by reset is not resumed.

## Timing
- `wr_en` is driven from a register. `pipe_ready` and `busy` are decoded from the registered state with no combinational path from `pipe_valid`.
- If w5 is accepted at cycle t:
  - Single write: `wr_en` is high at t+1 only. `pipe_ready` is 0 at t+1 and 1 at t+2.
  - Broadcast: `wr_en` is high at t+1 … t+`N_CHAN`, with `wr_chan` = k at t+1+k. `pipe_ready` is 1 at t+`N_CHAN`+1.
- Minimum frame period: 7 cycles for a single write, 6+`N_CHAN` cycles for a broadcast.
- Rejected frames (invalid channel): the state is IDLE at t+1, `err_count` updates at t+1, and `wr_en` never rises.
- Timeout: with the last word accepted at cycle s, the block returns to IDLE and `err_count` increments at s+`TIMEOUT`+1.
- `pipe_valid` held high while `pipe_ready` is low is legal; the word is accepted once `pipe_ready` returns high.

## Test plan
- Single write: words 0x0004, 0x0003, 0x1234, 0x5678, 0x9ABC, 0x0001 → one `wr_en` pulse 1 cycle after the last word with `wr_addr`=4, `wr_chan`=3, `wr_data`=0x1_9ABC_5678_1234.
- Broadcast: w1=0x8000 with data 0x0007 → 20 consecutive `wr_en` cycles with `wr_chan` 0..19 and `wr_data`=7 throughout; `pipe_ready` low for exactly 20 cycles.
- Invalid channel: w1=0x0015 (channel 21) → no `wr_en`, `err_count`=1, the next valid frame issues normally.
- Timeout: send w0 and w1, then idle for `TIMEOUT`=16 cycles → IDLE at gap+1 and `err_count`=1; a fresh 6-word frame then writes correctly.
- Reset mid-broadcast: assert `rst_in` at the 5th `wr_en` cycle → `wr_en`=0 the next cycle, all outputs zeroed, `err_count`=0, no further strobes.
- Back-to-back: `pipe_valid` held high for 12 words (two single-write frames) → 2 strobes 7 cycles apart, with no word lost or duplicated.
